// File: rtl/contador_bcd_dupla_rampa.sv
// BCD counter and result latch for the dual-slope converter: counts the fixed
// integration time Tx, flags its end on enb_3, then measures Tm and latches it on ld falling.
module contador_bcd_dupla_rampa #(
    parameter int DIGITS    = 4,
    parameter int TX_DIGITS = 3
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  enb_0,
    input  logic                  rst_s,
    input  logic                  ld,
    output logic                  enb_3,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  valid
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tx_done_q, tx_done_d;
    logic                ovf_run_q, ovf_run_d;
    logic                enb_3_q, enb_3_d;
    logic                ld_q;
    logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                carry_v;
    logic                ld_fall_s;

    // Counter next state: one synchronous carry chain, cut at TX_DIGITS on the first low rollover
    always_comb begin
        count_d   = count_q;
        tx_done_d = tx_done_q;
        ovf_run_d = ovf_run_q;
        enb_3_d   = 1'b0;
        carry_v   = 1'b1;
        if (rst_s) begin
            count_d   = '0;
            tx_done_d = 1'b0;
            ovf_run_d = 1'b0;
        end else if (enb_0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry_v) begin
                    if ((i == TX_DIGITS) && !tx_done_q) begin
                        // End of Tx: swallow the carry so Tm starts from zero
                        tx_done_d = 1'b1;
                        enb_3_d   = 1'b1;
                        carry_v   = 1'b0;
                    end else if (count_q[4*i +: 4] >= 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry_v           = 1'b0;
                    end
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4];
                end
            end
            if (carry_v && tx_done_q) begin
                ovf_run_d = 1'b1;
            end else begin
                ovf_run_d = ovf_run_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    assign ld_fall_s = ld_q & ~ld;

    // Result latch: snapshot of pre-edge count and overrange on ld falling
    always_comb begin
        valid_d = ld_fall_s;
        if (ld_fall_s) begin
            bcd_out_d = count_q;
            ovf_d     = ovf_run_q;
        end else begin
            bcd_out_d = bcd_out_q;
            ovf_d     = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            tx_done_q <= 1'b0;
            ovf_run_q <= 1'b0;
            enb_3_q   <= 1'b0;
            ld_q      <= 1'b0;
            bcd_out_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            tx_done_q <= tx_done_d;
            ovf_run_q <= ovf_run_d;
            enb_3_q   <= enb_3_d;
            ld_q      <= ld;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign enb_3   = enb_3_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;
    assign valid   = valid_q;

endmodule
